// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared constants and helpers for the multiplexed 7-segment counter.
//   DIG_W        : bit width of one BCD digit
//   MMSS_MOD     : default per-digit moduli (MM:SS, digit 0 in the low nibble)
//   SEG7_*       : segment patterns {g,f,e,d,c,b,a}, active-high
//   seg7_decode  : 4-bit digit code -> 7-bit segment pattern
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam int DIG_W = 4;

    localparam logic [15:0] MMSS_MOD = {4'd6, 4'd10, 4'd6, 4'd10};

    localparam logic [6:0] SEG7_0     = 7'h3F;
    localparam logic [6:0] SEG7_1     = 7'h06;
    localparam logic [6:0] SEG7_2     = 7'h5B;
    localparam logic [6:0] SEG7_3     = 7'h4F;
    localparam logic [6:0] SEG7_4     = 7'h66;
    localparam logic [6:0] SEG7_5     = 7'h6D;
    localparam logic [6:0] SEG7_6     = 7'h7D;
    localparam logic [6:0] SEG7_7     = 7'h07;
    localparam logic [6:0] SEG7_8     = 7'h7F;
    localparam logic [6:0] SEG7_9     = 7'h6F;
    localparam logic [6:0] SEG7_BLANK = 7'h00;

    // Codes above 9 cannot occur because every digit modulus is at most 10;
    // they map to blank so a corrupted digit shows nothing rather than junk.
    function automatic logic [6:0] seg7_decode(input logic [DIG_W-1:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:    pat = SEG7_0;
            4'd1:    pat = SEG7_1;
            4'd2:    pat = SEG7_2;
            4'd3:    pat = SEG7_3;
            4'd4:    pat = SEG7_4;
            4'd5:    pat = SEG7_5;
            4'd6:    pat = SEG7_6;
            4'd7:    pat = SEG7_7;
            4'd8:    pat = SEG7_8;
            4'd9:    pat = SEG7_9;
            default: pat = SEG7_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/mod_digit.sv
// ---------------------------------------------------------------------------
// mod_digit
// One modulo-MOD up/down digit of a ripple-carry digit chain.
//   clk, rst    : clock, asynchronous active-high reset (value -> 0)
//   clr         : synchronous clear (value -> 0), dominates stepping
//   en          : digit chain enable (counter running)
//   down        : 0 = count up, 1 = count down
//   carry_in    : step request from the previous digit (or the tick)
//   value       : current digit value, 0..MOD-1
//   carry_out   : this step rolls over (up) or borrows (down)
// ---------------------------------------------------------------------------
module mod_digit
    import seg7_pkg::*;
#(
    parameter int MOD = 10
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             down,
    input  logic             carry_in,
    output logic [DIG_W-1:0] value,
    output logic             carry_out
);

    localparam logic [DIG_W-1:0] TOP = DIG_W'(MOD - 1);

    logic [DIG_W-1:0] r_value;
    logic             w_step;

    assign w_step    = en & carry_in;
    // Combinational so a whole chain of digits updates on the same edge.
    assign carry_out = w_step & (down ? (r_value == '0) : (r_value == TOP));
    assign value     = r_value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (w_step) begin
            if (down) begin
                r_value <= (r_value == '0) ? TOP : r_value - 1'b1;
            end else begin
                r_value <= (r_value == TOP) ? '0 : r_value + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_7seg_counter.sv
// ---------------------------------------------------------------------------
// mux_7seg_counter
// Mixed-radix up/down event counter with a time-multiplexed 7-segment driver.
//   clk, rst : clock, asynchronous active-high reset
//   start    : begin/resume counting (ignored while stop or clear is high)
//   stop     : pause counting, value held
//   clear    : synchronous zero of all digits and the prescaler
//   down     : count direction, 1 = down
//   bcd      : all digit values, digit 0 in [3:0]
//   running  : counter is running
//   wrap     : one-cycle pulse after a full rollover/borrow
//   seg      : segments {g,f,e,d,c,b,a} of the currently scanned digit
//   dig_en   : one-hot enable of the currently scanned digit
// ---------------------------------------------------------------------------
module mux_7seg_counter
    import seg7_pkg::*;
#(
    parameter int                          NUM_DIGITS = 4,
    parameter logic [DIG_W*NUM_DIGITS-1:0] DIGIT_MOD  = MMSS_MOD,
    parameter int                          CLK_DIV    = 1,
    parameter int                          SCAN_DIV   = 4,
    parameter int                          BLANK_LZ   = 0
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          clear,
    input  logic                          down,
    output logic [DIG_W*NUM_DIGITS-1:0]   bcd,
    output logic                          running,
    output logic                          wrap,
    output logic [6:0]                    seg,
    output logic [NUM_DIGITS-1:0]         dig_en
);

    localparam int PW = (CLK_DIV > 1)    ? $clog2(CLK_DIV)    : 1;
    localparam int SW = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_TOP = PW'(CLK_DIV - 1);
    localparam logic [SW-1:0] SCAN_TOP  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_TOP   = IW'(NUM_DIGITS - 1);

    // Illegal parameter sets stop elaboration.
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
        $error("mux_7seg_counter: NUM_DIGITS must be in 1..8");
    end
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("mux_7seg_counter: CLK_DIV must be >= 1");
    end
    if (SCAN_DIV < 1) begin : g_bad_scan_div
        $error("mux_7seg_counter: SCAN_DIV must be >= 1");
    end

    logic                        r_running;
    logic                        r_wrap;
    logic [PW-1:0]               r_presc;
    logic [SW-1:0]               r_scan_tmr;
    logic [IW-1:0]               r_scan_idx;

    logic                        w_tick;
    logic [NUM_DIGITS:0]         w_carry;
    logic [DIG_W*NUM_DIGITS-1:0] w_bcd;
    logic [NUM_DIGITS-1:0]       w_lz;
    logic [DIG_W-1:0]            w_cur_digit;
    logic                        w_cur_lz;
    logic                        w_blank;

    assign w_tick     = r_running & (r_presc == PRESC_TOP);
    assign w_carry[0] = w_tick;

    // Digit chain: each digit steps when everything below it rolls over.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        localparam int MOD_I = int'(DIGIT_MOD[DIG_W*i +: DIG_W]);
        if (MOD_I < 2 || MOD_I > 10) begin : g_bad_mod
            $error("mux_7seg_counter: every DIGIT_MOD nibble must be in 2..10");
        end
        mod_digit #(
            .MOD       (MOD_I)
        ) u_digit (
            .clk       (clk),
            .rst       (rst),
            .clr       (clear),
            .en        (r_running),
            .down      (down),
            .carry_in  (w_carry[i]),
            .value     (w_bcd[DIG_W*i +: DIG_W]),
            .carry_out (w_carry[i+1])
        );
    end

    // Control: clear > stop > start. clear leaves the run state alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_running <= 1'b0;
            r_wrap    <= 1'b0;
            r_presc   <= '0;
        end else begin
            // A rollover swallowed by clear is not reported.
            r_wrap <= w_carry[NUM_DIGITS] & ~clear;

            if (clear) begin
                r_presc <= '0;
            end else if (start && !stop && !r_running) begin
                // Fresh start: the first tick lands CLK_DIV edges later.
                r_presc <= '0;
            end else if (r_running) begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
            end

            if (!clear) begin
                if (stop) begin
                    r_running <= 1'b0;
                end else if (start) begin
                    r_running <= 1'b1;
                end
            end
        end
    end

    // Display scan runs regardless of the count state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_tmr <= '0;
            r_scan_idx <= '0;
        end else if (r_scan_tmr == SCAN_TOP) begin
            r_scan_tmr <= '0;
            r_scan_idx <= (r_scan_idx == IDX_TOP) ? '0 : r_scan_idx + 1'b1;
        end else begin
            r_scan_tmr <= r_scan_tmr + 1'b1;
        end
    end

    // w_lz[i] is set when digit i and every digit above it are zero.
    always_comb begin
        w_lz = '0;
        w_lz[NUM_DIGITS-1] = (w_bcd[DIG_W*(NUM_DIGITS-1) +: DIG_W] == '0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            w_lz[i] = w_lz[i+1] & (w_bcd[DIG_W*i +: DIG_W] == '0);
        end
    end

    always_comb begin
        w_cur_digit = '0;
        w_cur_lz    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_scan_idx == IW'(i)) begin
                w_cur_digit = w_bcd[DIG_W*i +: DIG_W];
                w_cur_lz    = w_lz[i];
            end
        end
    end

    // Digit 0 is never blanked so an all-zero value still shows "0".
    assign w_blank = (BLANK_LZ != 0) && (r_scan_idx != '0) && w_cur_lz;

    assign seg     = w_blank ? SEG7_BLANK : seg7_decode(w_cur_digit);
    assign dig_en  = NUM_DIGITS'(1) << r_scan_idx;
    assign bcd     = w_bcd;
    assign running = r_running;
    assign wrap    = r_wrap;

endmodule

// File: tb/tb_mux_7seg_counter.sv
// ---------------------------------------------------------------------------
// tb_mux_7seg_counter
// Directed bench: dut A uses default parameters (MM:SS, CLK_DIV=1),
// dut B uses CLK_DIV=5 with leading-zero blanking.
// ---------------------------------------------------------------------------
module tb_mux_7seg_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_start = 0, a_stop = 0, a_clear = 0, a_down = 0;
    logic [15:0] a_bcd;
    logic        a_running, a_wrap;
    logic [6:0]  a_seg;
    logic [3:0]  a_dig_en;

    logic        b_start = 0, b_stop = 0, b_clear = 0, b_down = 0;
    logic [15:0] b_bcd;
    logic        b_running, b_wrap;
    logic [6:0]  b_seg;
    logic [3:0]  b_dig_en;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_7seg_counter u_dut_a (
        .clk     (clk),
        .rst     (rst),
        .start   (a_start),
        .stop    (a_stop),
        .clear   (a_clear),
        .down    (a_down),
        .bcd     (a_bcd),
        .running (a_running),
        .wrap    (a_wrap),
        .seg     (a_seg),
        .dig_en  (a_dig_en)
    );

    mux_7seg_counter #(
        .CLK_DIV  (5),
        .BLANK_LZ (1)
    ) u_dut_b (
        .clk     (clk),
        .rst     (rst),
        .start   (b_start),
        .stop    (b_stop),
        .clear   (b_clear),
        .down    (b_down),
        .bcd     (b_bcd),
        .running (b_running),
        .wrap    (b_wrap),
        .seg     (b_seg),
        .dig_en  (b_dig_en)
    );

    typedef struct {
        logic        start;
        logic        stop;
        logic        clear;
        logic        down;
        logic [15:0] bcd;
        logic        run;
        logic        wrap;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_start = 0; a_stop = 0; a_clear = 0; a_down = 0;
        b_start = 0; b_stop = 0; b_clear = 0; b_down = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [15:0] mmss(input int n);
        int m, mm, ss;
        m  = n % 3600;
        mm = m / 60;
        ss = m % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [6:0] blank_exp(input logic [3:0] den);
        case (den)
            4'd1:    return 7'h5B;
            4'd2:    return 7'h66;
            default: return 7'h00;
        endcase
    endfunction

    initial begin
        int bad;
        int wraps;
        int exp_v;
        bit reached;
        logic [3:0] seen;

        // ---------------- reset and idle ----------------
        do_reset();
        chk("rst_bcd",    a_bcd,     16'h0000);
        chk("rst_run",    a_running, 1'b0);
        chk("rst_wrap",   a_wrap,    1'b0);
        chk("rst_dig_en", a_dig_en,  4'h1);
        chk("rst_seg",    a_seg,     7'h3F);

        bad = 0;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (a_dig_en !== 4'(1 << ((e / 4) % 4))) bad++;
            if (a_seg !== 7'h3F) bad++;
            if (a_bcd !== 16'h0000 || a_running !== 1'b0 || a_wrap !== 1'b0) bad++;
        end
        chk("idle_scan_errors", bad, 0);

        // ---------------- control table on dut A ----------------
        //          start stop clear down  bcd       run  wrap
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h5959, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h5958, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h5959, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};

        for (int r = 0; r < 14; r++) begin
            a_start = tbl[r].start;
            a_stop  = tbl[r].stop;
            a_clear = tbl[r].clear;
            a_down  = tbl[r].down;
            step();
            chk($sformatf("tbl%0d_bcd", r),  a_bcd,     tbl[r].bcd);
            chk($sformatf("tbl%0d_run", r),  a_running, tbl[r].run);
            chk($sformatf("tbl%0d_wrap", r), a_wrap,    tbl[r].wrap);
        end

        // ---------------- full up rollover, CLK_DIV=1 ----------------
        do_reset();
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        chk("roll_start_run", a_running, 1'b1);
        chk("roll_start_bcd", a_bcd, 16'h0000);
        bad = 0;
        wraps = 0;
        for (int n = 1; n <= 3601; n++) begin
            step();
            if (a_bcd !== mmss(n)) bad++;
            if (a_wrap === 1'b1) wraps++;
            if (n == 59)   chk("roll_0059", a_bcd, 16'h0059);
            if (n == 60)   chk("roll_0100", a_bcd, 16'h0100);
            if (n == 599)  chk("roll_0959", a_bcd, 16'h0959);
            if (n == 600)  chk("roll_1000", a_bcd, 16'h1000);
            if (n == 3599) chk("roll_5959_wrap", a_wrap, 1'b0);
            if (n == 3600) begin
                chk("roll_3600_bcd",  a_bcd,  16'h0000);
                chk("roll_3600_wrap", a_wrap, 1'b1);
            end
            if (n == 3601) chk("roll_3601_wrap", a_wrap, 1'b0);
        end
        chk("roll_model_errors", bad, 0);
        chk("roll_wrap_count", wraps, 1);

        // ---------------- asynchronous reset mid-count ----------------
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_bcd",    a_bcd,     16'h0000);
        chk("midrst_run",    a_running, 1'b0);
        chk("midrst_wrap",   a_wrap,    1'b0);
        chk("midrst_dig_en", a_dig_en,  4'h1);
        chk("midrst_seg",    a_seg,     7'h3F);

        // ---------------- prescaler, CLK_DIV=5 ----------------
        do_reset();
        bad = 0;
        for (int e = 0; e <= 10; e++) begin
            b_start = (e == 0);
            step();
            exp_v = (e < 5) ? 0 : (e < 10) ? 1 : 2;
            if (e == 4 || e == 5 || e == 9 || e == 10)
                chk($sformatf("presc_run_e%0d", e), b_bcd, exp_v);
            else if (b_bcd !== 16'(exp_v)) bad++;
        end
        b_start = 1'b0;
        chk("presc_run_errors", bad, 0);

        do_reset();
        bad = 0;
        for (int e = 0; e <= 25; e++) begin
            b_start = (e == 0) || (e == 20);
            b_stop  = (e == 7);
            step();
            exp_v = (e < 5) ? 0 : (e < 25) ? 1 : 2;
            if (b_bcd !== 16'(exp_v)) bad++;
            if (e == 7)  chk("pause_stop_run", b_running, 1'b0);
            if (e == 19) chk("pause_held_bcd", b_bcd, 16'h0001);
            if (e == 24) chk("pause_pre_bcd", b_bcd, 16'h0001);
            if (e == 25) chk("pause_resume_bcd", b_bcd, 16'h0002);
        end
        b_start = 1'b0;
        b_stop  = 1'b0;
        chk("pause_errors", bad, 0);

        // ---------------- leading-zero blanking at 0x0042 ----------------
        reached = 1'b0;
        for (int c = 0; c < 400; c++) begin
            step();
            if (b_bcd === 16'h0042) begin
                reached = 1'b1;
                break;
            end
        end
        chk("blank_reach_0042", reached, 1'b1);
        b_stop = 1'b1;
        step();
        b_stop = 1'b0;
        chk("blank_hold_bcd", b_bcd, 16'h0042);
        chk("blank_hold_run", b_running, 1'b0);

        bad = 0;
        seen = 4'h0;
        for (int c = 0; c < 16; c++) begin
            step();
            seen = seen | b_dig_en;
            if (b_dig_en !== 4'h1 && b_dig_en !== 4'h2 && b_dig_en !== 4'h4 && b_dig_en !== 4'h8)
                bad++;
            else if (b_seg !== blank_exp(b_dig_en))
                bad++;
        end
        chk("blank_seg_errors", bad, 0);
        chk("blank_digits_seen", seen, 4'hF);
        chk("blank_final_bcd", b_bcd, 16'h0042);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_7seg_counter.md
Name: mux_7seg_counter

Overview:
Parametrised multi-digit, mixed-radix up/down event counter with a built-in time-multiplexed 7-segment display driver. It is the successor to the team's fixed two-digit 0..59 counter. It adds:
- N digits, each with its own modulus.
- Start/stop/clear control, a count-rate prescaler and direction control.
- A wrap pulse.
- Direct segment/digit-enable outputs for a shared-segment multi-digit display on the board.

Parameters:
NUM_DIGITS, 4, number of digits (1..8)
DIGIT_MOD, {4'd6,4'd10,4'd6,4'd10}, packed 4 bits per digit, MSB digit first; modulus of each digit (2..10). The default gives MM:SS, 00:00..59:59
CLK_DIV, 1, clk cycles per count tick (>=1)
SCAN_DIV, 4, clk cycles each digit is driven (>=1)
BLANK_LZ, 0, 1 = blank leading zero digits (digit 0 is never blanked)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  level-sampled; begins or resumes counting
stop  in  1  level-sampled; pauses counting and holds the value
clear  in  1  synchronous; zeroes all digits and the prescaler
down  in  1  0 = count up, 1 = count down; sampled on each tick
bcd  out  4*NUM_DIGITS  current digit values, digit 0 in [3:0]
running  out  1  counter is running
wrap  out  1  one-cycle pulse on full rollover
seg  out  7  segments {g,f,e,d,c,b,a}, active-high
dig_en  out  NUM_DIGITS  one-hot digit enable, active-high

Behaviour:
- Reset (async, rst=1): bcd=0, running=0, wrap=0, prescaler=0, scan index=0, scan timer=0, dig_en=1 (digit 0), seg=7'h3F.
- Control priority per edge is clear > stop > start.
  - clear: all digits and the prescaler go to 0; running is unchanged.
  - stop: running goes to 0.
  - start (when stop=0): running goes to 1. If running was 0, the prescaler goes to 0.
- Prescaler:
  - Increments on every edge with running=1.
  - When running=1 and prescaler==CLK_DIV-1, a tick occurs and the prescaler returns to 0.
  - With start asserted at edge k, the first tick and count update occur at edge k+CLK_DIV. With CLK_DIV=1 the count updates on every edge while running.
- Tick, up direction:
  - Digit 0 increments.
  - A digit at DIGIT_MOD-1 goes to 0 and carries into the next digit.
  - A carry out of the top digit raises wrap for 1 cycle; the value is then all zeros.
- Tick, down direction:
  - A digit at 0 goes to DIGIT_MOD-1 and borrows from the next digit.
  - A borrow out of the top digit raises wrap; the value is then all digits at modulus-1.
- clear coincident with a tick: clear wins, and wrap is not asserted.
- Digit values never exceed modulus-1.
- Paused state (running=0): bcd holds its value, the prescaler holds, and the display keeps scanning.
- Scan:
  - Free-running whenever not in reset, independent of running.
  - The scan timer counts 0..SCAN_DIV-1; at terminal count the scan index advances (NUM_DIGITS-1 wraps to 0).
  - dig_en = one-hot of the scan index, decoded combinationally from registered state.
  - seg = 7-seg decode of bcd[index]. Codes 0-9 use the standard patterns; codes >9 are unreachable.
- Blanking: with BLANK_LZ=1, seg=0 for digit i>0 if digits i..NUM_DIGITS-1 are all zero. dig_en still asserts.
- Reset mid-count: everything returns to reset values immediately, and no wrap pulse is produced.
- Parameter legality: any DIGIT_MOD nibble outside 2..10, CLK_DIV=0, SCAN_DIV=0 or NUM_DIGITS outside 1..8 is an elaboration error.

Decomposition:
- Package seg7_pkg:
  - SEG7 font constants for 0-9 and blank.
  - seg7_decode function (4-bit to 7-bit).
  - MM:SS default DIGIT_MOD constant.
  - Digit width constant (4).
- Sub-module mod_digit: one digit register, with ports clk, rst, clr, en, down, carry_in and parameter MOD. It outputs the value and carry_out (rollover/borrow). It is instantiated NUM_DIGITS times in a generate loop: carry_in of digit 0 = tick, carry_out of the top digit = wrap source.
- Top level holds the control state, prescaler, scan logic and blanking.

Test Plan:
- Reset and idle: rst pulse, then 20 cycles with no start -> bcd=0, running=0, wrap=0. dig_en cycles 1,2,4,8 every 4 clk; seg=7'h3F throughout.
- Up rollover with default params and CLK_DIV=1: start for 1 cycle, run 3600 cycles -> bcd passes 0x0059 -> 0x0100 and 0x0959 -> 0x1000. At edge 3600, bcd=0x0000 and wrap is high for exactly 1 cycle.
- Down borrow: start, down=1 from 0x0000 -> next tick gives 0x5959 with wrap=1, then 0x5958.
- Control priority: assert start+stop together -> running stays 0. Assert clear together with a tick at 0x5959 (up) -> bcd=0x0000, wrap=0.
- Prescaler and pause with CLK_DIV=5: start at edge k -> first increment at k+5, the next at k+10. Stop at k+7, restart at k+20 -> next increment at k+25, with the value held at 0x0001 in between.
- Blanking with BLANK_LZ=1 and bcd=0x0042: when dig_en=8 or 4, seg=0. When dig_en=2, seg=7'h66 (4). When dig_en=1, seg=7'h5B (2).
